// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch unit with PC, fetch queue and redirect/fault handling
//
// Fetches 32-bit words from a byte-addressed, combinational instruction memory.
// The returned words are buffered in a DEPTH-entry {pc,instr} queue and handed
// to decode over a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_addr           byte address to instruction memory (current PC)
//   imem_instr          instruction word returned for imem_addr
//   if_valid/if_ready   queue-head handshake toward decode
//   if_instr/if_pc      queue-head instruction and its PC
//   redirect_valid      one-cycle branch/jump pulse; redirect_target is the new PC
//   halt_req            level; blocks new fetches while high
//   fetch_fault         sticky misaligned/out-of-range PC indication
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          MEM_BYTES    = 1024,
    parameter int          DEPTH        = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    output logic        fetch_fault
);

    localparam int              PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              CW        = $clog2(DEPTH + 1);
    localparam logic [31:0]     LAST_WORD = 32'(MEM_BYTES - 4);
    localparam logic [CW-1:0]   FULL_CNT  = CW'(DEPTH);
    localparam logic [PW-1:0]   PTR_LAST  = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          fault_q, fault_d;

    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];

    logic          pc_legal;
    logic          tgt_legal;
    logic          pop;
    logic          push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    assign pc_legal  = (pc_q[1:0] == 2'b00) && (pc_q <= LAST_WORD);
    assign tgt_legal = (redirect_target[1:0] == 2'b00) && (redirect_target <= LAST_WORD);

    assign pop  = (count_q != '0) && if_ready;
    // A full queue may still accept a word when the head leaves in the same cycle.
    assign push = (state_q == S_RUN) && !halt_req && !redirect_valid && pc_legal &&
                  ((count_q != FULL_CNT) || pop);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        fault_d  = fault_q;
        if (redirect_valid) begin
            // Redirect wins over everything: flush, drop any same-cycle pop.
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            pc_d     = redirect_target;
            state_d  = tgt_legal ? S_RUN : S_HALT;
            fault_d  = !tgt_legal;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_RUN;
                S_RUN: begin
                    // Covers running off the end of memory after the last legal push.
                    if (!pc_legal) begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
                pc_d     = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_VECTOR;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            fault_q  <= fault_d;
        end
    end

    // Queue storage carries no reset; validity is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr_q]    <= pc_q;
            q_instr[wr_ptr_q] <= imem_instr;
        end
    end

    assign imem_addr   = pc_q;
    assign if_valid    = (count_q != '0);
    assign if_pc       = if_valid ? q_pc[rd_ptr_q]    : 32'h0;
    assign if_instr    = if_valid ? q_instr[rd_ptr_q] : 32'h0;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam int MEM_BYTES = 1024;
    localparam int DEPTH     = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr, imem_instr, if_instr, if_pc, redirect_target;
    logic        if_valid, if_ready, redirect_valid, halt_req, fetch_fault;

    logic [7:0]  mem_b [MEM_BYTES];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mword(input logic [31:0] a);
        int i;
        if (a > 32'(MEM_BYTES - 4)) return 32'hBAD0_BAD0;
        i = int'(a);
        return {mem_b[i], mem_b[i+1], mem_b[i+2], mem_b[i+3]};
    endfunction

    assign imem_instr = mword(imem_addr);

    instr_fetch_unit #(
        .RESET_VECTOR(32'h0000_0000),
        .MEM_BYTES   (MEM_BYTES),
        .DEPTH       (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .halt_req       (halt_req),
        .fetch_fault    (fetch_fault)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int a, input logic [31:0] w);
        mem_b[a]   = w[31:24];
        mem_b[a+1] = w[23:16];
        mem_b[a+2] = w[15:8];
        mem_b[a+3] = w[7:0];
    endtask

    // Leaves rst_n released just after an edge; the next edge is edge 1.
    task automatic do_reset;
        rst_n = 1'b0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        halt_req = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic redirect_to(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_target = t;
        tick;
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        halt_req = 1'b0;
        tick;
        checks++;
        if ({if_valid, if_instr, if_pc, imem_addr, fetch_fault} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b instr=%h pc=%h addr=%h fault=%b expected all zero",
                     if_valid, if_instr, if_pc, imem_addr, fetch_fault);
        end
    endtask

    task automatic test_stream;
        logic [31:0] e;
        if_ready = 1'b1;
        rst_n = 1'b1;
        tick;
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_edge1_valid: got %b expected 0", if_valid);
        end
        tick;
        checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'h00020493}) begin
            errors++;
            $display("FAIL stream_first: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=00020493",
                     if_valid, if_pc, if_instr);
        end
        for (int k = 1; k < 19; k++) begin
            tick;
            e = 32'(4 * k);
            checks++;
            if ({if_valid, if_pc, if_instr} !== {1'b1, e, mword(e)}) begin
                errors++;
                $display("FAIL stream_seq: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                         if_valid, if_pc, if_instr, e, mword(e));
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] e;
        do_reset;
        tick;
        tick;
        repeat (5) tick;
        checks++;
        if ({if_valid, if_pc, imem_addr} !== {1'b1, 32'h0, 32'h8}) begin
            errors++;
            $display("FAIL backpressure_hold: got v=%b pc=%h addr=%h expected v=1 pc=0 addr=8",
                     if_valid, if_pc, imem_addr);
        end
        if_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            e = 32'(4 * k);
            checks++;
            if ({if_valid, if_pc, if_instr} !== {1'b1, e, mword(e)}) begin
                errors++;
                $display("FAIL backpressure_release: got v=%b pc=%h expected v=1 pc=%h",
                         if_valid, if_pc, e);
            end
            tick;
        end
    endtask

    task automatic test_redirect;
        if_ready = 1'b0;
        tick;
        tick;
        checks++;
        if (if_valid !== 1'b1 || imem_addr !== if_pc + 32'd8) begin
            errors++;
            $display("FAIL redirect_prefill: got v=%b addr=%h head=%h expected full queue",
                     if_valid, imem_addr, if_pc);
        end
        if_ready = 1'b1;
        redirect_to(32'h2C);
        checks++;
        if ({if_valid, imem_addr} !== {1'b0, 32'h2C}) begin
            errors++;
            $display("FAIL redirect_flush: got v=%b addr=%h expected v=0 addr=2c", if_valid, imem_addr);
        end
        tick;
        checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h2C, 32'h00460363}) begin
            errors++;
            $display("FAIL redirect_target: got v=%b pc=%h instr=%h expected v=1 pc=2c instr=00460363",
                     if_valid, if_pc, if_instr);
        end
        tick;
        checks++;
        if ({if_valid, if_pc} !== {1'b1, 32'h30}) begin
            errors++;
            $display("FAIL redirect_next: got v=%b pc=%h expected v=1 pc=30", if_valid, if_pc);
        end
    endtask

    task automatic test_fault;
        if_ready = 1'b1;
        redirect_to(32'h2E);
        checks++;
        if ({fetch_fault, if_valid} !== 2'b10) begin
            errors++;
            $display("FAIL misaligned_fault: got fault=%b v=%b expected fault=1 v=0", fetch_fault, if_valid);
        end
        repeat (3) tick;
        checks++;
        if ({fetch_fault, if_valid, imem_addr} !== {2'b10, 32'h2E}) begin
            errors++;
            $display("FAIL halt_hold: got fault=%b v=%b addr=%h expected fault=1 v=0 addr=2e",
                     fetch_fault, if_valid, imem_addr);
        end
        redirect_to(32'h0);
        checks++;
        if (fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_clear: got %b expected 0", fetch_fault);
        end
        tick;
        checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'h00020493}) begin
            errors++;
            $display("FAIL fault_resume: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=00020493",
                     if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_overrun;
        logic [31:0] got[$];
        if_ready = 1'b1;
        redirect_to(32'h3F8);
        for (int i = 0; i < 8; i++) begin
            if (if_valid) got.push_back(if_pc);
            tick;
        end
        checks++;
        if (got.size() != 2 || got[0] !== 32'h3F8 || got[1] !== 32'h3FC) begin
            errors++;
            $display("FAIL overrun_pcs: got %0d entries first=%h expected 2 entries 3f8,3fc",
                     got.size(), (got.size() > 0) ? got[0] : 32'hx);
        end
        checks++;
        if ({fetch_fault, if_valid} !== 2'b10) begin
            errors++;
            $display("FAIL overrun_fault: got fault=%b v=%b expected fault=1 v=0", fetch_fault, if_valid);
        end
        redirect_to(32'h0);
        tick;
        redirect_to(32'h400);
        checks++;
        if ({fetch_fault, if_valid} !== 2'b10) begin
            errors++;
            $display("FAIL range_fault: got fault=%b v=%b expected fault=1 v=0", fetch_fault, if_valid);
        end
    endtask

    task automatic test_back_to_back;
        if_ready = 1'b0;
        redirect_to(32'h100);
        repeat (3) tick;
        checks++;
        if ({if_valid, if_pc, imem_addr} !== {1'b1, 32'h100, 32'h108}) begin
            errors++;
            $display("FAIL full_fill: got v=%b pc=%h addr=%h expected v=1 pc=100 addr=108",
                     if_valid, if_pc, imem_addr);
        end
        if_ready = 1'b1;
        tick;
        if_ready = 1'b0;
        tick;
        checks++;
        if ({if_valid, if_pc, imem_addr} !== {1'b1, 32'h104, 32'h10C}) begin
            errors++;
            $display("FAIL full_push_pop: got v=%b pc=%h addr=%h expected v=1 pc=104 addr=10c",
                     if_valid, if_pc, imem_addr);
        end
        if_ready = 1'b1;
        redirect_to(32'h200);
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_pop_flush: got v=%b expected 0", if_valid);
        end
        tick;
        checks++;
        if ({if_valid, if_pc} !== {1'b1, 32'h200}) begin
            errors++;
            $display("FAIL redirect_pop_target: got v=%b pc=%h expected v=1 pc=200", if_valid, if_pc);
        end
        if_ready = 1'b0;
        tick;
        halt_req = 1'b1;
        if_ready = 1'b1;
        tick;
        checks++;
        if ({if_valid, if_pc, imem_addr} !== {1'b1, 32'h204, 32'h208}) begin
            errors++;
            $display("FAIL halt_drain1: got v=%b pc=%h addr=%h expected v=1 pc=204 addr=208",
                     if_valid, if_pc, imem_addr);
        end
        repeat (3) tick;
        checks++;
        if ({if_valid, imem_addr} !== {1'b0, 32'h208}) begin
            errors++;
            $display("FAIL halt_empty: got v=%b addr=%h expected v=0 addr=208", if_valid, imem_addr);
        end
        halt_req = 1'b0;
        tick;
        checks++;
        if ({if_valid, if_pc} !== {1'b1, 32'h208}) begin
            errors++;
            $display("FAIL halt_resume: got v=%b pc=%h expected v=1 pc=208", if_valid, if_pc);
        end
        tick;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({if_valid, imem_addr, fetch_fault} !== {1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got v=%b addr=%h fault=%b expected v=0 addr=0 fault=0",
                     if_valid, imem_addr, fetch_fault);
        end
        tick;
        rst_n = 1'b1;
        tick;
        tick;
        checks++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'h00020493}) begin
            errors++;
            $display("FAIL reset_restart: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=00020493",
                     if_valid, if_pc, if_instr);
        end
    endtask

    // Reference: decode must see an unbroken +4 PC stream starting at the last
    // redirect target, with words read from the program image, and nothing at
    // all after an illegal redirect until the next legal one.
    task automatic test_random;
        logic [31:0] exp_pc;
        logic [31:0] t;
        logic        blocked;
        logic        redir;
        logic        legal;
        int          deliveries;
        do_reset;
        tick;
        tick;
        exp_pc = 32'h0;
        blocked = 1'b0;
        deliveries = 0;
        for (int c = 0; c < 600; c++) begin
            redir = ($urandom_range(0, 99) < 5);
            t = 32'h0;
            if (redir) begin
                case ($urandom_range(0, 7))
                    5:       t = 32'h3F0 + 32'(4 * $urandom_range(0, 3));
                    6:       t = 32'(4 * $urandom_range(0, 250) + $urandom_range(1, 3));
                    7:       t = 32'h400 + 32'(4 * $urandom_range(0, 64));
                    default: t = 32'(4 * $urandom_range(0, 255));
                endcase
            end
            redirect_valid = redir;
            redirect_target = t;
            if_ready = ($urandom_range(0, 3) != 0);
            halt_req = ($urandom_range(0, 7) == 0);
            if (!redir && if_valid && if_ready) begin
                checks++;
                if (blocked || if_pc !== exp_pc || if_instr !== mword(exp_pc)) begin
                    errors++;
                    $display("FAIL random_delivery: got pc=%h instr=%h expected pc=%h instr=%h blocked=%b",
                             if_pc, if_instr, exp_pc, mword(exp_pc), blocked);
                end
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
            tick;
            redirect_valid = 1'b0;
            if (redir) begin
                legal = (t[1:0] == 2'b00) && (t <= 32'(MEM_BYTES - 4));
                checks++;
                if ({fetch_fault, if_valid} !== {!legal, 1'b0}) begin
                    errors++;
                    $display("FAIL random_redirect: target=%h got fault=%b v=%b expected fault=%b v=0",
                             t, fetch_fault, if_valid, !legal);
                end
                exp_pc = t;
                blocked = !legal;
            end
        end
        halt_req = 1'b0;
        checks++;
        if (deliveries < 60) begin
            errors++;
            $display("FAIL random_throughput: got %0d deliveries expected at least 60", deliveries);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem_b[i] = 8'($urandom);
        set_word(32'h00, 32'h00020493);
        set_word(32'h2C, 32'h00460363);
        test_reset;
        test_stream;
        test_backpressure;
        test_redirect;
        test_fault;
        test_overrun;
        test_back_to_back;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
